// File: rtl/rtc_clock.sv
// Real-time clock: prescaled seconds counter with 24h internal time,
// 12h/24h display decode, one-shot time load and a minute-resolution alarm.
module rtc_clock #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       mode_24h,
    input  logic       set_valid,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       am_pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       alarm_hit,
    output logic       set_ack,
    output logic       set_err
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    h24_q, h24_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_tick_q, day_tick_d;
    logic          alarm_hit_q, alarm_hit_d;
    logic          set_ack_q, set_ack_d;
    logic          set_err_q, set_err_d;

    logic advance_c;
    logic set_ok_c;
    logic alarm_ok_c;
    logic day_wrap_c;

    // Qualifiers for the current edge
    assign advance_c  = run && (presc_q == PRESC_MAX);
    assign set_ok_c   = set_valid && (set_hours < 5'd24) && (set_minutes < 6'd60)
                        && (set_seconds < 6'd60);
    assign alarm_ok_c = (alarm_hours < 5'd24) && (alarm_minutes < 6'd60);
    assign day_wrap_c = (h24_q == 5'd23) && (min_q == 6'd59) && (sec_q == 6'd59);

    // Next-state: prescaler, time roll-over, load and status pulses
    always_comb begin
        presc_d     = presc_q;
        h24_d       = h24_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_tick_d  = 1'b0;
        day_tick_d  = 1'b0;
        alarm_hit_d = 1'b0;
        set_ack_d   = 1'b0;
        set_err_d   = 1'b0;

        if (run) begin
            presc_d = advance_c ? '0 : presc_q + PW'(1);
        end

        if (set_ok_c) begin
            // A valid load overrides any advance and restarts the second
            h24_d     = set_hours;
            min_d     = set_minutes;
            sec_d     = set_seconds;
            presc_d   = '0;
            set_ack_d = 1'b1;
        end else begin
            set_err_d = set_valid;
            if (advance_c) begin
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d = 6'd0;
                        h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
                sec_tick_d  = 1'b1;
                day_tick_d  = day_wrap_c;
                alarm_hit_d = alarm_en && alarm_ok_c && (h24_d == alarm_hours)
                              && (min_d == alarm_minutes) && (sec_d == 6'd0);
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= '0;
            h24_q       <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            sec_tick_q  <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            h24_q       <= h24_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_tick_q  <= sec_tick_d;
            day_tick_q  <= day_tick_d;
            alarm_hit_q <= alarm_hit_d;
            set_ack_q   <= set_ack_d;
            set_err_q   <= set_err_d;
        end
    end

    // Display decode: hour format follows mode_24h immediately, state untouched
    always_comb begin
        if (mode_24h) begin
            hours = h24_q;
        end else if (h24_q == 5'd0) begin
            hours = 5'd12;
        end else if (h24_q > 5'd12) begin
            hours = h24_q - 5'd12;
        end else begin
            hours = h24_q;
        end
    end

    assign am_pm     = (h24_q >= 5'd12);
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign sec_tick  = sec_tick_q;
    assign day_tick  = day_tick_q;
    assign alarm_hit = alarm_hit_q;
    assign set_ack   = set_ack_q;
    assign set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_clock.sv
// Testbench for rtc_clock: seconds-of-day reference model feeding a scoreboard,
// plus directed checks on the key time-of-day corners.
module tb_rtc_clock;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n, run, mode_24h, set_valid, alarm_en;
    logic [4:0] set_hours, alarm_hours;
    logic [5:0] set_minutes, set_seconds, alarm_minutes;
    logic [4:0] hours, hours_f;
    logic [5:0] minutes, seconds, minutes_f, seconds_f;
    logic       am_pm, sec_tick, day_tick, alarm_hit, set_ack, set_err;
    logic       am_pm_f, sec_tick_f, day_tick_f, alarm_hit_f, set_ack_f, set_err_f;

    always #5 clk = ~clk;

    rtc_clock #(.TICKS_PER_SEC(N)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode_24h(mode_24h),
        .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds), .alarm_en(alarm_en), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .hours(hours), .minutes(minutes),
        .seconds(seconds), .am_pm(am_pm), .sec_tick(sec_tick), .day_tick(day_tick),
        .alarm_hit(alarm_hit), .set_ack(set_ack), .set_err(set_err)
    );

    rtc_clock #(.TICKS_PER_SEC(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .run(run), .mode_24h(mode_24h),
        .set_valid(set_valid), .set_hours(set_hours), .set_minutes(set_minutes),
        .set_seconds(set_seconds), .alarm_en(alarm_en), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .hours(hours_f), .minutes(minutes_f),
        .seconds(seconds_f), .am_pm(am_pm_f), .sec_tick(sec_tick_f), .day_tick(day_tick_f),
        .alarm_hit(alarm_hit_f), .set_ack(set_ack_f), .set_err(set_err_f)
    );

    typedef struct {
        int t;
        bit st;
        bit dt;
        bit ah;
        bit ack;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   m_t = 0;
    int   m_p = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_hours(input int t, input bit m24);
        int h;
        h = t / 3600;
        if (m24) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    // Reference model of one rising edge, using the inputs currently driven
    task automatic model_edge();
        exp_t e;
        bit   adv;
        bit   ok;
        e.st = 0; e.dt = 0; e.ah = 0; e.ack = 0; e.err = 0;
        if (!rst_n) begin
            m_t = 0;
            m_p = 0;
        end else begin
            adv = run && (m_p == N - 1);
            if (run) m_p = (m_p + 1) % N;
            ok = set_valid && (set_hours < 24) && (set_minutes < 60) && (set_seconds < 60);
            if (ok) begin
                m_t = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                m_p = 0;
                e.ack = 1;
            end else begin
                e.err = set_valid;
                if (adv) begin
                    m_t  = (m_t + 1) % 86400;
                    e.st = 1;
                    e.dt = (m_t == 0);
                    e.ah = alarm_en && (alarm_hours < 24) && (alarm_minutes < 60)
                           && (m_t == int'(alarm_hours) * 3600 + int'(alarm_minutes) * 60);
                end
            end
        end
        e.t = m_t;
        sb.push_back(e);
    endtask

    // Push expectation, clock once, pop and compare all outputs
    task automatic cycle(input string tag);
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".hours"},   32'(hours),     32'(exp_hours(e.t, mode_24h)));
            chk({tag, ".minutes"}, 32'(minutes),   32'((e.t / 60) % 60));
            chk({tag, ".seconds"}, 32'(seconds),   32'(e.t % 60));
            chk({tag, ".am_pm"},   32'(am_pm),     32'((e.t / 3600) >= 12));
            chk({tag, ".sec_tick"},  32'(sec_tick),  32'(e.st));
            chk({tag, ".day_tick"},  32'(day_tick),  32'(e.dt));
            chk({tag, ".alarm_hit"}, 32'(alarm_hit), 32'(e.ah));
            chk({tag, ".set_ack"},   32'(set_ack),   32'(e.ack));
            chk({tag, ".set_err"},   32'(set_err),   32'(e.err));
        end
    endtask

    task automatic load(input int h, input int m, input int s, input string tag);
        set_hours   = 5'(h);
        set_minutes = 6'(m);
        set_seconds = 6'(s);
        set_valid   = 1'b1;
        cycle(tag);
        set_valid   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mode_24h = 1'b0; set_valid = 1'b0;
        set_hours = '0; set_minutes = '0; set_seconds = '0;
        alarm_en = 1'b0; alarm_hours = '0; alarm_minutes = '0;

        // Reset: 12h mode shows 12:00:00 AM
        repeat (2) cycle("reset");
        chk("reset.hours12", 32'(hours), 32'd12);
        chk("reset.am", 32'(am_pm), 32'd0);
        chk("reset.sec", 32'(seconds), 32'd0);

        // First advance four cycles after reset release
        rst_n = 1'b1; run = 1'b1;
        repeat (3) cycle("run");
        chk("run.sec_before", 32'(seconds), 32'd0);
        chk("fast.sec3", 32'(seconds_f), 32'd3);
        chk("fast.tick", 32'(sec_tick_f), 32'd1);
        cycle("run4");
        chk("run4.sec", 32'(seconds), 32'd1);
        chk("run4.tick", 32'(sec_tick), 32'd1);
        repeat (8) cycle("run_more");

        // Noon transition and mode toggle
        load(11, 59, 59, "ld1159");
        chk("ld1159.ack", 32'(set_ack), 32'd1);
        chk("ld1159.hours", 32'(hours), 32'd11);
        repeat (4) cycle("noon");
        chk("noon.hours", 32'(hours), 32'd12);
        chk("noon.pm", 32'(am_pm), 32'd1);
        chk("noon.min", 32'(minutes), 32'd0);
        mode_24h = 1'b1; #1;
        chk("noon.h24", 32'(hours), 32'd12);
        chk("noon.pm24", 32'(am_pm), 32'd1);
        mode_24h = 1'b0; #1;
        chk("noon.h12", 32'(hours), 32'd12);
        load(0, 15, 0, "ld0015");
        chk("ld0015.hours", 32'(hours), 32'd12);
        chk("ld0015.am", 32'(am_pm), 32'd0);
        mode_24h = 1'b1; #1;
        chk("ld0015.h24", 32'(hours), 32'd0);
        mode_24h = 1'b0;

        // Midnight wrap
        load(23, 59, 59, "ld2359");
        repeat (4) cycle("midnight");
        chk("midnight.day_tick", 32'(day_tick), 32'd1);
        chk("midnight.sec_tick", 32'(sec_tick), 32'd1);
        chk("midnight.hours", 32'(hours), 32'd12);
        chk("midnight.am", 32'(am_pm), 32'd0);

        // Alarm: hit, disabled, direct load, out-of-range minutes
        alarm_en = 1'b1; alarm_hours = 5'd7; alarm_minutes = 6'd30;
        load(7, 29, 59, "ld0729");
        repeat (4) cycle("alarm");
        chk("alarm.hit", 32'(alarm_hit), 32'd1);
        chk("alarm.min", 32'(minutes), 32'd30);
        alarm_en = 1'b0;
        load(7, 29, 59, "ld0729b");
        repeat (4) cycle("alarm_off");
        chk("alarm_off.hit", 32'(alarm_hit), 32'd0);
        alarm_en = 1'b1;
        load(7, 30, 0, "ld0730");
        chk("ld0730.hit", 32'(alarm_hit), 32'd0);
        repeat (4) cycle("alarm_after_load");
        alarm_hours = 5'd6; alarm_minutes = 6'd60;
        load(6, 59, 59, "ld0659");
        repeat (4) cycle("alarm_bad");
        chk("alarm_bad.hit", 32'(alarm_hit), 32'd0);
        chk("alarm_bad.hours", 32'(hours), 32'd7);
        alarm_en = 1'b0;

        // Out-of-range loads keep time and prescaler phase
        cycle("pre_err");
        load(24, 0, 0, "err_h24");
        chk("err_h24.err", 32'(set_err), 32'd1);
        chk("err_h24.hours", 32'(hours), 32'd7);
        load(10, 60, 0, "err_m60");
        chk("err_m60.err", 32'(set_err), 32'd1);
        cycle("after_err");
        chk("after_err.sec", 32'(seconds), 32'd1);
        chk("after_err.tick", 32'(sec_tick), 32'd1);

        // Load coincident with prescaler at terminal count
        repeat (3) cycle("to_p3");
        load(1, 2, 3, "ld_p3");
        chk("ld_p3.ack", 32'(set_ack), 32'd1);
        chk("ld_p3.no_tick", 32'(sec_tick), 32'd0);
        chk("ld_p3.sec", 32'(seconds), 32'd3);
        repeat (3) cycle("ld_p3_wait");
        chk("ld_p3_wait.sec", 32'(seconds), 32'd3);
        cycle("ld_p3_adv");
        chk("ld_p3_adv.sec", 32'(seconds), 32'd4);

        // Freeze
        run = 1'b0;
        repeat (10) cycle("frozen");
        chk("frozen.sec", 32'(seconds), 32'd4);
        run = 1'b1;
        repeat (4) cycle("resume");
        chk("resume.sec", 32'(seconds), 32'd5);

        // Reset mid-run overrides a valid load
        repeat (2) cycle("pre_rst");
        rst_n = 1'b0;
        load(5, 5, 5, "rst_load");
        rst_n = 1'b1;
        chk("rst_load.hours", 32'(hours), 32'd12);
        chk("rst_load.min", 32'(minutes), 32'd0);
        chk("rst_load.sec", 32'(seconds), 32'd0);
        cycle("post_rst");
        chk("post_rst.no_ack", 32'(set_ack), 32'd0);
        repeat (3) cycle("post_rst_run");
        chk("post_rst.sec", 32'(seconds), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_clock.md
RTC_CLOCK -- requirements
Module: rtc_clock

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50000000, clk cycles per second (>=1); prescaler width = max(1, clog2(TICKS_PER_SEC)).
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset is synchronous and active-low.
REQ-004 run  in  1  1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-005 mode_24h  in  1  1 = hours output 0-23; 0 = hours output 1-12.
REQ-006 set_valid  in  1  single-cycle load request for set_hours/set_minutes/set_seconds.
REQ-007 set_hours  in  5  load value, always 24h encoding (0-23).
REQ-008 set_minutes, set_seconds  in  6 each  load values (0-59).
REQ-009 alarm_en  in  1  enables alarm compare.
REQ-010 alarm_hours  in  5, alarm_minutes  in  6  alarm time, 24h encoding.
REQ-011 hours  out  5  current hour in the selected mode.
REQ-012 minutes, seconds  out  6 each  current minute/second.
REQ-013 am_pm  out  1  0 = AM, 1 = PM; valid in both modes.
REQ-014 sec_tick, day_tick, alarm_hit, set_ack, set_err  out  1 each  single-cycle status pulses.

Function
REQ-015 Time SHALL be held internally as h24 (0-23), min (0-59), sec (0-59); h24 SHALL be the only hour state.
REQ-016 hours SHALL be combinational from h24 and mode_24h: 24h mode = h24; 12h mode = 12 if h24==0, h24 if 1..12, h24-12 if 13..23.
REQ-017 am_pm SHALL be 1 iff h24 >= 12; mode_24h changes SHALL take effect on the same cycle without altering state.
REQ-018 Prescaler SHALL count 0..TICKS_PER_SEC-1 while run=1, wrap to 0, and generate an advance on the edge where it equals TICKS_PER_SEC-1.
REQ-019 Advance: sec+1; sec 59 -> 0 with min+1; min 59 -> 0 with h24+1; h24 23 -> 0.
REQ-020 sec_tick SHALL be 1 for exactly the cycle in which the advanced time is first visible.
REQ-021 day_tick SHALL pulse coincident with sec_tick on the 23:59:59 -> 00:00:00 advance only.
REQ-022 alarm_hit SHALL pulse coincident with sec_tick when alarm_en=1 and the new time equals alarm_hours:alarm_minutes:00; loads SHALL NOT raise alarm_hit.
REQ-023 Alarm values with alarm_hours>23 or alarm_minutes>59 SHALL never match.
REQ-024 set_valid=1 with all fields in range SHALL load time and clear the prescaler to 0 at that edge; set_ack pulses the following cycle, coincident with loaded values.
REQ-025 set_valid=1 with any field out of range SHALL leave time and prescaler unchanged (prescaler continues normally) and pulse set_err the following cycle.
REQ-026 Valid load and advance on the same edge: load wins; no sec_tick, day_tick or alarm_hit that cycle.
REQ-027 Loads SHALL be accepted regardless of run.
REQ-028 TICKS_PER_SEC=1 SHALL advance every cycle while run=1.

Reset
REQ-029 While rst_n=0 at a rising edge: h24=0, min=0, sec=0, prescaler=0, all pulse outputs 0 (12h reads 12:00:00 AM).
REQ-030 Reset SHALL override set_valid and run on the same edge; pending advances are discarded.
REQ-031 After rst_n rises, the first advance SHALL occur TICKS_PER_SEC cycles later with run=1.

Verification (TICKS_PER_SEC=4)
REQ-032 Reset, run=1, mode_24h=0 -> hours=12, am_pm=0, 00:00; sec_tick every 4th cycle; seconds=1 after 4 cycles.
REQ-033 Load 11:59:59, wait one advance -> 12:00:00, am_pm=1 (12h: hours=12); toggle mode_24h -> hours=12 both modes; load 00:xx -> 12h hours=12, am_pm=0.
REQ-034 Load 23:59:59 -> next advance gives 00:00:00 with day_tick=1, sec_tick=1; 12h shows 12 AM.
REQ-035 alarm_en=1, alarm 07:30, load 07:29:59 -> alarm_hit with 07:30:00; alarm_en=0 repeat -> no pulse; load 07:30:00 directly -> no pulse.
REQ-036 Load 24:00:00 or 10:60:00 -> set_err pulse, time and prescaler phase unchanged; valid load coincident with prescaler=3 -> loaded values, no sec_tick, next advance 4 cycles later.
REQ-037 run=0 for 10 cycles -> time and prescaler frozen, no pulses; rst_n=0 mid-run with set_valid=1 -> 00:00:00, no set_ack.
